// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a shared data bus.
// Grants are registered; a grant holder is pre-empted after MAX_HOLD cycles under contention.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t     r_state, w_state_nxt;
  logic       r_sel, w_sel_nxt;
  logic       r_last, w_last_nxt;
  logic [7:0] r_hold, w_hold_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (req0 && req1)  w_state_nxt = r_last ? GNT0 : GNT1;
        else if (req0)     w_state_nxt = GNT0;
        else if (req1)     w_state_nxt = GNT1;
      end
      GNT0: begin
        if (!req0)                          w_state_nxt = req1 ? GNT1 : IDLE;
        else if (req1 && r_hold == HOLD_MAX) w_state_nxt = GNT1;
      end
      GNT1: begin
        if (!req1)                          w_state_nxt = req0 ? GNT0 : IDLE;
        else if (req0 && r_hold == HOLD_MAX) w_state_nxt = GNT0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Entering a grant restarts the hold count; staying counts up to saturation; IDLE freezes all.
  always_comb begin
    w_sel_nxt  = r_sel;
    w_last_nxt = r_last;
    w_hold_nxt = r_hold;
    if (w_state_nxt != IDLE && w_state_nxt != r_state) begin
      w_sel_nxt  = (w_state_nxt == GNT1);
      w_last_nxt = (w_state_nxt == GNT1);
      w_hold_nxt = 8'd1;
    end else if (w_state_nxt != IDLE && r_hold < HOLD_MAX) begin
      w_hold_nxt = r_hold + 8'd1;
    end
  end

  assign gnt0      = (r_state == GNT0);
  assign gnt1      = (r_state == GNT1);
  assign sel       = r_sel;
  assign out_valid = (gnt0 & req0) | (gnt1 & req1);
  assign out_data  = out_valid ? (r_sel ? data1 : data0) : '0;

endmodule
